hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 66 ++++++
 rtl/hazard_ctrl_if.sv | 13 +
 rtl/hazard_detect.sv | 11 +
 rtl/hazard_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state enum, pipeline control bundle and its canned values.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MD_WAIT  = 2'd2
  } state_t;

  localparam logic [4:0] REG_X0           = 5'd0;
  localparam int         MAX_WAIT_DEFAULT = 255;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic mem_wb_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } ctrl_t;

  function automatic ctrl_t ctrl_run();
    ctrl_t c;
    c              = '0;
    c.pc_write     = 1'b1;
    c.if_id_write  = 1'b1;
    c.id_ex_write  = 1'b1;
    c.ex_mem_write = 1'b1;
    c.mem_wb_write = 1'b1;
    return c;
  endfunction

  // Reset keeps every register writable but squashes all stages to bubbles.
  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c              = ctrl_run();
    c.if_id_flush  = 1'b1;
    c.id_ex_flush  = 1'b1;
    c.ex_mem_flush = 1'b1;
    c.mem_wb_flush = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_mem_freeze();
    ctrl_t c;
    c              = '0;
    c.mem_wb_flush = 1'b1;
    return c;
  endfunction

  // Front end holds while the mul/div result occupies EX; a bubble enters MEM.
  function automatic ctrl_t ctrl_md_freeze();
    ctrl_t c;
    c              = ctrl_run();
    c.pc_write     = 1'b0;
    c.if_id_write  = 1'b0;
    c.id_ex_write  = 1'b0;
    c.ex_mem_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Load-use query bundle: the EX load destination against the ID source registers.
interface hazard_ctrl_if;

  logic       mem_read;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       load_use;

  modport master (output mem_read, rd, rs1, rs2, input load_use);
  modport slave  (input mem_read, rd, rs1, rs2, output load_use);

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use comparator; x0 is never a real dependency.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  hazard_ctrl_if.slave lu
);

  assign lu.load_use = lu.mem_read && (lu.rd != REG_X0) &&
                       ((lu.rd == lu.rs1) || (lu.rd == lu.rs2));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, mul/div freeze, branch flush, load-use stall.
// Mul/div support (MD_* ports, MD_WAIT state) is built only when HAZARD_CTRL_MULDIV_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_RD_i,
  input  logic [4:0]       IF_ID_RS1_i,
  input  logic [4:0]       IF_ID_RS2_i,
  input  logic             Branch_Taken_i,
  input  logic             EX_MEM_MemReq_i,
  input  logic             DMem_Ack_i,
`ifdef HAZARD_CTRL_MULDIV_EN
  input  logic             MD_Start_i,
  input  logic             MD_Done_i,
`endif
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             ID_EX_Write_o,
  output logic             EX_MEM_Write_o,
  output logic             MEM_WB_Write_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Flush_o,
  output logic             EX_MEM_Flush_o,
  output logic             MEM_WB_Flush_o,
  output logic             Err_o,
  output logic [CNT_W-1:0] Stall_Cnt_o
);

  localparam int                WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_t             state;
  state_t             state_next;
  ctrl_t              ctrl;
  ctrl_t              run_ctrl;
  logic               mem_stall;
  logic               load_use;
  logic               timeout_hit;
  logic               err_q;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [WAIT_W-1:0]  wait_cnt_inc;
  logic [CNT_W-1:0]   stall_cnt;

  hazard_ctrl_if lu_if ();

  assign lu_if.mem_read = ID_EX_MemRead_i;
  assign lu_if.rd       = ID_EX_RD_i;
  assign lu_if.rs1      = IF_ID_RS1_i;
  assign lu_if.rs2      = IF_ID_RS2_i;
  assign load_use       = lu_if.load_use;

  hazard_detect u_detect (
    .lu (lu_if.slave)
  );

  assign mem_stall    = EX_MEM_MemReq_i && !DMem_Ack_i;
  assign wait_cnt_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
  assign timeout_hit  = !rst_i && (state == ST_MEM_WAIT) && (wait_cnt_inc == WAIT_MAX);

  // Unfrozen behaviour: a taken branch squashes the wrong path, which also
  // removes the consumer of any load-use hazard, so it wins over the stall.
  always_comb begin
    run_ctrl = ctrl_run();
    if (Branch_Taken_i) begin
      run_ctrl.if_id_flush = 1'b1;
      run_ctrl.id_ex_flush = 1'b1;
    end else if (load_use) begin
      run_ctrl.pc_write    = 1'b0;
      run_ctrl.if_id_write = 1'b0;
      run_ctrl.id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    ctrl       = ctrl_run();
    state_next = state;
    if (rst_i) begin
      ctrl       = ctrl_reset();
      state_next = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            ctrl       = ctrl_mem_freeze();
            state_next = ST_MEM_WAIT;
          end
`ifdef HAZARD_CTRL_MULDIV_EN
          else if (MD_Start_i) begin
            ctrl       = ctrl_md_freeze();
            state_next = ST_MD_WAIT;
          end
`endif
          else begin
            ctrl = run_ctrl;
          end
        end
        ST_MEM_WAIT: begin
          if (DMem_Ack_i) begin
            ctrl       = run_ctrl;
            state_next = ST_RUN;
          end else begin
            ctrl = ctrl_mem_freeze();
          end
        end
`ifdef HAZARD_CTRL_MULDIV_EN
        // A memory stall freezes everything but must not lose the pending mul/div.
        ST_MD_WAIT: begin
          if (mem_stall) begin
            ctrl = ctrl_mem_freeze();
          end else if (MD_Done_i) begin
            ctrl       = run_ctrl;
            state_next = ST_RUN;
          end else begin
            ctrl = ctrl_md_freeze();
          end
        end
`endif
        default: state_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Wait counter restarts whenever a fresh memory wait begins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt  <= '0;
      err_q     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if ((state != ST_MEM_WAIT) && (state_next == ST_MEM_WAIT)) begin
        wait_cnt <= '0;
      end else if (state == ST_MEM_WAIT) begin
        wait_cnt <= wait_cnt_inc;
      end
      err_q <= err_q || timeout_hit;
      if (!ctrl.pc_write && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign PC_Write_o     = ctrl.pc_write;
  assign IF_ID_Write_o  = ctrl.if_id_write;
  assign ID_EX_Write_o  = ctrl.id_ex_write;
  assign EX_MEM_Write_o = ctrl.ex_mem_write;
  assign MEM_WB_Write_o = ctrl.mem_wb_write;
  assign IF_ID_Flush_o  = ctrl.if_id_flush;
  assign ID_EX_Flush_o  = ctrl.id_ex_flush;
  assign EX_MEM_Flush_o = ctrl.ex_mem_flush;
  assign MEM_WB_Flush_o = ctrl.mem_wb_flush;
  assign Err_o          = err_q || timeout_hit;
  assign Stall_Cnt_o    = stall_cnt;

endmodule
